// File: rtl/text_pkg.sv
// rtl/text_pkg.sv - opcodes, geometry defaults and FSM encoding for the text buffer
package text_pkg;

  localparam int         COLS_DEF  = 80;
  localparam int         ROWS_DEF  = 30;
  localparam logic [5:0] BLANK_DEF = 6'h00;

  typedef enum logic [1:0] {
    OP_PUT       = 2'd0,
    OP_NEWLINE   = 2'd1,
    OP_BACKSPACE = 2'd2,
    OP_CLEAR     = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_CLEAR_ALL = 2'd1,
    ST_CLEAR_ROW = 2'd2
  } state_e;

endpackage

// File: rtl/text_ram.sv
// rtl/text_ram.sv - simple dual-port character store, one write port, one registered read port
module text_ram #(
  parameter int DEPTH = 2400,
  parameter int AW    = 12,
  parameter int DW    = 6
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  // Read-before-write: a same-cycle read of the written cell returns the old code.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/text_buffer_ctrl.sv
// rtl/text_buffer_ctrl.sv - character-cell text buffer: writer command FSM plus VGA read port
module text_buffer_ctrl
  import text_pkg::*;
#(
  parameter int         COLS  = COLS_DEF,
  parameter int         ROWS  = ROWS_DEF,
  parameter logic [5:0] BLANK = BLANK_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [5:0] cmd_char,
  input  logic [6:0] rd_col,
  input  logic [4:0] rd_row,
  output logic [5:0] rd_char,
  output logic [6:0] cursor_col,
  output logic [4:0] cursor_row,
  output logic       busy
);

  localparam int CELLS = ROWS * COLS;
  localparam int AW    = $clog2(CELLS);

  state_e        state, state_nx;
  logic [AW-1:0] clr_cnt;
  logic [AW-1:0] row_base, cur_addr;
  logic          accept, last_col, advance;
  logic [4:0]    next_row;
  logic          we;
  logic [AW-1:0] waddr;
  logic [5:0]    wdata;
  logic          rd_oob, rd_oob_q;
  logic [AW-1:0] raddr;
  logic [5:0]    ram_q;

  assign accept   = cmd_valid && cmd_ready;
  assign last_col = int'(cursor_col) == COLS - 1;
  assign advance  = accept && ((cmd_op == OP_PUT && last_col) || cmd_op == OP_NEWLINE);
  assign next_row = (int'(cursor_row) == ROWS - 1) ? 5'd0 : cursor_row + 5'd1;
  assign row_base = AW'(int'(cursor_row) * COLS);
  assign cur_addr = row_base + AW'(cursor_col);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_CLEAR_ALL;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (accept && cmd_op == OP_CLEAR) state_nx = ST_CLEAR_ALL;
        else if (advance)                 state_nx = ST_CLEAR_ROW;
      end
      ST_CLEAR_ALL: if (int'(clr_cnt) == CELLS - 1) state_nx = ST_IDLE;
      ST_CLEAR_ROW: if (int'(clr_cnt) == COLS - 1)  state_nx = ST_IDLE;
      default:      state_nx = ST_CLEAR_ALL;
    endcase
  end

  always_comb begin
    cmd_ready = 1'b0;
    busy      = 1'b1;
    we        = 1'b0;
    waddr     = cur_addr;
    wdata     = BLANK;
    case (state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) begin
          if (cmd_op == OP_PUT) begin
            we    = 1'b1;
            wdata = cmd_char;
          end else if (cmd_op == OP_BACKSPACE && cursor_col != 7'd0) begin
            we    = 1'b1;
            waddr = cur_addr - AW'(1);
          end
        end
      end
      ST_CLEAR_ALL: begin
        we    = 1'b1;
        waddr = clr_cnt;
      end
      ST_CLEAR_ROW: begin
        we    = 1'b1;
        waddr = row_base + clr_cnt;
      end
      default: ;
    endcase
  end

  // The clear counter idles at zero so every sweep starts at its first cell.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clr_cnt    <= '0;
      cursor_col <= 7'd0;
      cursor_row <= 5'd0;
    end else begin
      clr_cnt <= (state == ST_IDLE || state_nx == ST_IDLE) ? '0 : clr_cnt + AW'(1);
      if (accept) begin
        case (cmd_op)
          OP_PUT: begin
            if (last_col) begin
              cursor_col <= 7'd0;
              cursor_row <= next_row;
            end else begin
              cursor_col <= cursor_col + 7'd1;
            end
          end
          OP_NEWLINE: begin
            cursor_col <= 7'd0;
            cursor_row <= next_row;
          end
          OP_BACKSPACE: if (cursor_col != 7'd0) cursor_col <= cursor_col - 7'd1;
          OP_CLEAR: begin
            cursor_col <= 7'd0;
            cursor_row <= 5'd0;
          end
          default: ;
        endcase
      end
    end
  end

  assign rd_oob = int'(rd_col) >= COLS || int'(rd_row) >= ROWS;
  assign raddr  = rd_oob ? '0 : AW'(int'(rd_row) * COLS + int'(rd_col));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rd_oob_q <= 1'b1;
    else       rd_oob_q <= rd_oob;
  end

  assign rd_char = rd_oob_q ? BLANK : ram_q;

  text_ram #(
    .DEPTH (CELLS),
    .AW    (AW),
    .DW    (6)
  ) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (raddr),
    .rdata (ram_q)
  );

endmodule

// File: tb/tb_text_buffer_ctrl.sv
// tb/tb_text_buffer_ctrl.sv - scoreboard bench for text_buffer_ctrl
module tb_text_buffer_ctrl;
  import text_pkg::*;

  localparam int COLS = 80;
  localparam int ROWS = 30;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_op = 2'd0;
  logic [5:0] cmd_char = 6'd0;
  logic [6:0] rd_col = 7'd0;
  logic [4:0] rd_row = 5'd0;
  logic       cmd_ready, busy;
  logic [5:0] rd_char;
  logic [6:0] cursor_col;
  logic [4:0] cursor_row;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [5:0] exp;
    string      tag;
  } rd_exp_t;

  rd_exp_t sb[$];
  rd_exp_t mon_e;
  logic    rd_req = 1'b0;
  logic    rd_req_q = 1'b0;

  always #5 clk = ~clk;

  text_buffer_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_char   (cmd_char),
    .rd_col     (rd_col),
    .rd_row     (rd_row),
    .rd_char    (rd_char),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row),
    .busy       (busy)
  );

  // Read data is due the clock after the address; compare on the falling edge.
  always @(posedge clk) rd_req_q <= rd_req;

  always @(negedge clk) begin
    if (rd_req_q) begin
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL sb_underflow: read data %h with no expectation queued", rd_char);
      end else begin
        mon_e = sb.pop_front();
        if (rd_char !== mon_e.exp) begin
          n_fail++;
          $display("FAIL %s: got %h expected %h", mon_e.tag, rd_char, mon_e.exp);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(string tag, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic check_cursor(string tag, int r, int c);
    check({tag, "_row"}, int'(cursor_row), r);
    check({tag, "_col"}, int'(cursor_col), c);
  endtask

  task automatic rd(int r, int c, logic [5:0] exp, string tag);
    rd_row = 5'(r);
    rd_col = 7'(c);
    rd_req = 1'b1;
    sb.push_back('{exp: exp, tag: tag});
    tick();
    rd_req = 1'b0;
  endtask

  task automatic send(logic [1:0] op, logic [5:0] ch);
    int n;
    n = 0;
    while (!cmd_ready && n < 3000) begin
      tick();
      n++;
    end
    check("send_ready", int'(cmd_ready), 1);
    cmd_op    = op;
    cmd_char  = ch;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(int exp, string tag);
    int n;
    n = 0;
    while (busy && n < 5000) begin
      tick();
      n++;
    end
    check(tag, n, exp);
  endtask

  initial begin
    int n;
    int not_ready;

    // Reset state
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_cmd_ready", int'(cmd_ready), 0);
    check("reset_busy", int'(busy), 1);
    check_cursor("reset_cursor", 0, 0);
    check("reset_rd_char", int'(rd_char), 0);

    // Power-up clear
    reset = 1'b0;
    wait_idle(2400, "init_clear_cycles");
    check("init_ready", int'(cmd_ready), 1);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        rd(r, c, 6'h00, "init_blank");

    // Back-to-back PUTs
    cmd_op    = OP_PUT;
    cmd_char  = 6'h31;
    cmd_valid = 1'b1;
    check("b2b_ready0", int'(cmd_ready), 1);
    tick();
    check("b2b_ready1", int'(cmd_ready), 1);
    cmd_char = 6'h37;
    tick();
    cmd_valid = 1'b0;
    check("b2b_ready2", int'(cmd_ready), 1);
    check_cursor("b2b_cursor", 0, 2);
    rd(0, 0, 6'h31, "b2b_cell00");
    rd(0, 1, 6'h37, "b2b_cell01");

    // Read and write of the same cell in one cycle
    rd_row    = 5'd0;
    rd_col    = 7'd2;
    rd_req    = 1'b1;
    sb.push_back('{exp: 6'h00, tag: "same_cycle_old"});
    cmd_op    = OP_PUT;
    cmd_char  = 6'h15;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    rd_req    = 1'b0;
    rd(0, 2, 6'h15, "write_visible_next");
    check_cursor("put3_cursor", 0, 3);

    // BACKSPACE blanks the previous cell
    send(OP_BACKSPACE, 6'h00);
    check_cursor("bs_cursor", 0, 2);
    rd(0, 2, 6'h00, "bs_blank");
    rd(0, 1, 6'h37, "bs_neighbor");

    // CLEAR
    send(OP_CLEAR, 6'h00);
    check("clear_busy", int'(busy), 1);
    check_cursor("clear_cursor", 0, 0);
    wait_idle(2400, "clear_cycles");
    rd(0, 0, 6'h00, "clear_cell00");
    rd(0, 1, 6'h00, "clear_cell01");

    // 80 PUTs fill row 0, then the row clear holds off a waiting command
    not_ready = 0;
    cmd_op    = OP_PUT;
    cmd_valid = 1'b1;
    for (int i = 0; i < COLS; i++) begin
      cmd_char = 6'((i % 63) + 1);
      if (!cmd_ready) not_ready++;
      tick();
    end
    check("fill_all_accepted", not_ready, 0);
    cmd_char = 6'h3F;
    check("fill_busy", int'(busy), 1);
    check("fill_ready_low", int'(cmd_ready), 0);
    n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    cmd_valid = 1'b0;
    check("row_clear_cycles", n, 80);
    check_cursor("fill_cursor", 1, 0);
    for (int c = 0; c < COLS; c++) rd(0, c, 6'((c % 63) + 1), "fill_row0");
    for (int c = 0; c < COLS; c++) rd(1, c, 6'h00, "fill_row1_blank");

    // Out-of-range reads
    send(OP_PUT, 6'h05);
    rd(1, 0, 6'h05, "cell10");
    rd(0, 80, 6'h00, "oob_col");
    rd(30, 0, 6'h00, "oob_row");
    rd(31, 127, 6'h00, "oob_both");

    // BACKSPACE at column 0 and mid-row
    send(OP_NEWLINE, 6'h00);
    wait_idle(80, "nl1_cycles");
    send(OP_NEWLINE, 6'h00);
    wait_idle(80, "nl2_cycles");
    check_cursor("nl2_cursor", 3, 0);
    send(OP_BACKSPACE, 6'h00);
    check_cursor("bs_col0_cursor", 3, 0);
    check("bs_col0_ready", int'(cmd_ready), 1);
    send(OP_PUT, 6'h0A);
    send(OP_PUT, 6'h0B);
    send(OP_PUT, 6'h0C);
    send(OP_PUT, 6'h0D);
    check_cursor("row3_cursor", 3, 4);
    send(OP_BACKSPACE, 6'h00);
    check_cursor("bs_mid_cursor", 3, 3);
    rd(3, 3, 6'h00, "bs_mid_blank");
    rd(3, 2, 6'h0C, "bs_mid_neighbor");

    // Row wrap from the last row clears row 0
    for (int i = 0; i < 26; i++) begin
      send(OP_NEWLINE, 6'h00);
      wait_idle(80, "nl_walk_cycles");
    end
    for (int i = 0; i < 5; i++) send(OP_PUT, 6'(8'h21 + i));
    check_cursor("row29_cursor", 29, 5);
    send(OP_NEWLINE, 6'h00);
    check("wrap_busy", int'(busy), 1);
    check_cursor("wrap_cursor", 0, 0);
    wait_idle(80, "wrap_clear_cycles");
    for (int c = 0; c < COLS; c++) rd(0, c, 6'h00, "wrap_row0_blank");
    rd(1, 0, 6'h05, "wrap_keep10");
    rd(3, 0, 6'h0A, "wrap_keep30");
    rd(3, 2, 6'h0C, "wrap_keep32");
    for (int c = 0; c < 5; c++) rd(29, c, 6'(8'h21 + c), "wrap_keep_row29");
    rd(29, 5, 6'h00, "wrap_row29_tail");

    // Reset in the middle of a full clear restarts it from the first cell
    send(OP_CLEAR, 6'h00);
    repeat (1000) tick();
    check("midclear_busy", int'(busy), 1);
    reset = 1'b1;
    tick();
    check("midreset_busy", int'(busy), 1);
    check("midreset_ready", int'(cmd_ready), 0);
    check_cursor("midreset_cursor", 0, 0);
    reset = 1'b0;
    wait_idle(2400, "restart_clear_cycles");
    check("restart_ready", int'(cmd_ready), 1);
    rd(3, 0, 6'h00, "restart_cell30");

    tick();
    tick();
    check("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/text_buffer_ctrl.md
TEXT_BUFFER_CTRL -- requirements
Module: text_buffer_ctrl

Interface
REQ-001 SHALL have parameter COLS, default 80, meaning character columns (640/8).
REQ-002 SHALL have parameter ROWS, default 30, meaning character rows (480/16).
REQ-003 SHALL have parameter BLANK, default 6'h00, meaning the font code written when clearing.
REQ-004 SHALL have port clk, input, 1, single system clock; all logic on rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port cmd_valid, input, 1, writer command present.
REQ-007 SHALL have port cmd_ready, output, 1, controller accepts a command this cycle.
REQ-008 SHALL have port cmd_op, input, 2, opcode: 0 PUT, 1 NEWLINE, 2 BACKSPACE, 3 CLEAR.
REQ-009 SHALL have port cmd_char, input, 6, font code for PUT.
REQ-010 SHALL have port rd_col, input, 7, VGA-side column (h[9:3]).
REQ-011 SHALL have port rd_row, input, 5, VGA-side row (v[8:4]).
REQ-012 SHALL have port rd_char, output, 6, font code at (rd_row,rd_col), one clock after address.
REQ-013 SHALL have port cursor_col, output, 7, current write column.
REQ-014 SHALL have port cursor_row, output, 5, current write row.
REQ-015 SHALL have port busy, output, 1, clear sequence in progress.

Function
REQ-016 SHALL store ROWS*COLS 6-bit codes; address = row*COLS + col; write port owned solely by controller; read port owned solely by VGA side.
REQ-017 SHALL implement FSM states IDLE, CLEAR_ALL, CLEAR_ROW; cmd_ready SHALL be 1 only in IDLE; busy SHALL be 1 in CLEAR_ALL or CLEAR_ROW.
REQ-018 SHALL accept a command only on a cycle with cmd_valid && cmd_ready; one command per cycle maximum; unaccepted commands have no effect.
REQ-019 PUT SHALL write cmd_char at cursor and increment cursor_col; if cursor_col was COLS-1, col->0 and row advance per REQ-021.
REQ-020 NEWLINE SHALL set col->0 and advance row per REQ-021, with no character write.
REQ-021 Row advance SHALL set row->row+1, wrapping ROWS-1 -> 0, then enter CLEAR_ROW, which writes BLANK to the COLS cells of the new row in exactly COLS cycles (col 0..COLS-1), then returns to IDLE.
REQ-022 BACKSPACE SHALL, if cursor_col>0, decrement col and write BLANK at the new position; at col 0 it is a no-op (no row retreat), cmd_ready stays 1.
REQ-023 CLEAR SHALL set cursor to (0,0) and enter CLEAR_ALL, writing BLANK to addresses 0..ROWS*COLS-1 in exactly ROWS*COLS cycles, then IDLE.
REQ-024 PUT without row advance and BACKSPACE SHALL leave FSM in IDLE, allowing back-to-back accepts every cycle.
REQ-025 Read of an address written in the same cycle SHALL return the old data; write visible on reads issued the following cycle.
REQ-026 rd_col>=COLS or rd_row>=ROWS SHALL return BLANK; cursor outputs SHALL never exceed COLS-1/ROWS-1.

Reset
REQ-027 Reset SHALL force cursor (0,0), cmd_ready 0, rd_char BLANK, busy 1, state CLEAR_ALL with clear counter 0.
REQ-028 Reset asserted mid-clear or mid-operation SHALL restart CLEAR_ALL from address 0 after deassertion; no partial command survives.

Structure
REQ-029 Package text_pkg SHALL hold opcode constants, COLS/ROWS defaults, BLANK code, and FSM state encoding.
REQ-030 Storage SHALL be sub-module text_ram (simple dual-port, synchronous read, 1 write/1 read port, inferable as block RAM).

Verification
REQ-031 Reset release -> busy=1 for exactly 2400 cycles, then cmd_ready=1; all 2400 reads return 6'h00.
REQ-032 PUT 6'h31,6'h37 back-to-back -> cells (0,0)=6'h31,(0,1)=6'h37, cursor (0,2), cmd_ready held 1.
REQ-033 80 PUTs from (0,0) -> cursor (1,0), busy=1 for 80 cycles, row 1 all BLANK, cmd_ready ignored-valid not accepted meanwhile.
REQ-034 Cursor (29,5), NEWLINE -> cursor (0,0), row 0 cleared in 80 cycles, rows 1..29 unchanged.
REQ-035 BACKSPACE at (3,0) -> no change, no write; BACKSPACE at (3,4) -> cursor (3,3), cell (3,3)=BLANK.
REQ-036 reset pulsed at cycle 1000 of CLEAR_ALL -> clear restarts at 0, busy lasts 2400 cycles after release.
